// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive side of a 4-lane time-division multiplexed serial link.
//
// A frame is four consecutive accepted beats carrying lanes 0,1,2,3 in order.
// W frames make one word: every lane collects W bits, with the earliest frame
// in the MSB. When the lane-3 beat of the last frame is accepted, all four
// lane words are published on y0..y3 and out_valid pulses for one cycle.
// The block locks on the first beat flagged with sync. After that, sync is
// optional at frame boundaries. A sync seen mid-frame triggers a resync and
// pulses sync_err.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   din        serial lane bit, valid when din_valid is high
//   din_valid  beat qualifier; din and sync are ignored when low
//   sync       marks the accepted beat as lane 0 of a frame
//   y0..y3     registered lane words (W bits each)
//   out_valid  one-cycle pulse when y0..y3 take a completed word
//   sync_err   one-cycle pulse when sync arrives at a non-zero slot
//   slot       lane index that the next accepted beat will be written to
//   locked     high while the receiver is aligned (RUN state)
module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         out_valid,
  output logic         sync_err,
  output logic [1:0]   slot,
  output logic         locked
);

  // Frame counter range is 0..15, which covers the full legal range of W.
  localparam int FW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q,     state_d;
  logic [1:0]            slot_q,      slot_d;
  logic [FW-1:0]         frame_q,     frame_d;
  logic [3:0][W-1:0]     lane_q,      lane_d;
  logic [3:0][W-1:0]     y_q,         y_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sync_err_q,  sync_err_d;

  // NOTE: every signal gets its hold value first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    frame_d     = frame_q;
    lane_d      = lane_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Discard everything until a sync beat. That beat becomes lane 0,
        // frame 0 of the first word.
        if (din_valid && sync) begin
          state_d   = RUN;
          lane_d    = '0;
          lane_d[0] = W'(din);
          slot_d    = 2'd1;
          frame_d   = '0;
        end
      end

      RUN: begin
        if (din_valid) begin
          if (sync && (slot_q != 2'd0)) begin
            // Misaligned sync: drop the partial word and restart with this
            // beat as lane 0. This wins even over a word-completing beat.
            sync_err_d = 1'b1;
            lane_d     = '0;
            lane_d[0]  = W'(din);
            slot_d     = 2'd1;
            frame_d    = '0;
          end else begin
            // Shift left so the earliest frame of a word ends up in the MSB.
            lane_d[slot_q] = (lane_q[slot_q] << 1) | W'(din);
            slot_d         = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
              if (frame_q == FW'(W - 1)) begin
                // Publish lane_d rather than lane_q so the lane-3 bit of
                // this very beat is included.
                y_d         = lane_d;
                out_valid_d = 1'b1;
                frame_d     = '0;
              end else begin
                frame_d = frame_q + FW'(1);
              end
            end
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the working lanes are a handful of flops, not a RAM. Resetting
      // them costs nothing and keeps a stale word from ever appearing.
      state_q     <= IDLE;
      slot_q      <= '0;
      frame_q     <= '0;
      lane_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      frame_q     <= frame_d;
      lane_q      <= lane_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign y0        = y_q[0];
  assign y1        = y_q[1];
  assign y2        = y_q[2];
  assign y3        = y_q[3];
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign slot      = slot_q;
  assign locked    = (state_q == RUN);

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter W, default 1: number of frames per output word (bits collected per lane), legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 din  input  1  serial time-division stream, one lane bit per accepted beat.
REQ-005 din_valid  input  1  beat qualifier; din and sync are ignored when low.
REQ-006 sync  input  1  marks the accepted beat as slot 0 (lane 0) of a frame.
REQ-007 y0, y1, y2, y3  output  W each  registered lane words.
REQ-008 out_valid  output  1  one-cycle pulse when y0..y3 update with a complete word.
REQ-009 sync_err  output  1  one-cycle pulse on sync misalignment.
REQ-010 slot  output  2  lane index the next accepted beat will be written to (00..11).
REQ-011 locked  output  1  high while in RUN state.

Function
REQ-012 The block shall be the receive-side inverse of the 4:1 select mux: frame = 4 consecutive accepted beats, carrying lane 0, 1, 2, 3 in that order.
REQ-013 The block shall have two states, IDLE and RUN.
REQ-014 IDLE: beats without sync are discarded, slot stays 00, and locked is 0.
REQ-015 IDLE -> RUN: an accepted beat with sync=1 is stored as lane 0, frame 0, and slot becomes 01.
REQ-016 In RUN, each accepted beat shall be stored into lane slot of the working shift registers.
REQ-017 In RUN, slot shall increment modulo 4 on each accepted beat (wrap 11 -> 00).
REQ-018 In RUN, slot and all working state shall hold when din_valid=0.
REQ-019 Within a lane, the bit from the earliest frame of a word shall land in the MSB; the bit from frame W-1 shall land in the LSB.
REQ-020 A frame counter (0..W-1) shall increment when the lane-3 beat is accepted.
REQ-021 When the lane-3 beat of frame W-1 is accepted, working lanes shall copy to y0..y3 and out_valid shall be 1 in the next cycle.
REQ-022 Latency from that lane-3 beat edge to the out_valid/y update shall be exactly 1 clock.
REQ-023 After a word completes, the frame counter shall return to 0.
REQ-024 y0..y3 shall hold their value until the next completed word.
REQ-025 sync=1 on an accepted beat when slot=00 in RUN is legal and changes nothing.
REQ-026 sync=0 at slot 00 in RUN is also legal: after lock, sync is optional.
REQ-027 sync=1 on an accepted beat when slot!=00 in RUN:
- sync_err pulses 1 in the next cycle;
- the partial frame and partial word are discarded, with the frame counter cleared;
- the beat is taken as lane 0, frame 0 of a new word, and slot becomes 01;
- state remains RUN;
- y0..y3 are unchanged and no out_valid is raised.
REQ-028 A resync beat that coincides with what would otherwise complete a word (slot=11, last frame) shall be treated as a resync: no out_valid.
REQ-029 With W=1, every frame shall produce one word.

Reset
REQ-030 When rst=1 at a clock edge, all outputs shall go to 0 on that edge: y0..y3, out_valid, sync_err, slot and locked.
REQ-031 Reset shall also clear the frame counter and working lanes, and put the state in IDLE.
REQ-032 Reset shall take priority over any simultaneous beat.
REQ-033 Reset asserted mid-word shall discard the partial data with no out_valid.
REQ-034 After reset deasserts, a new sync is required to re-lock.

Verification
REQ-035 W=1, beats din=0,1,0,1 with sync on the first beat -> one cycle later out_valid=1 and {y3,y2,y1,y0}=1010; locked=1 and slot=00.
REQ-036 W=1, beats 1,0,1,1 with sync on the first beat, then 1,0,1,1 again with no sync -> two out_valid pulses, each with {y3,y2,y1,y0}=1101.
REQ-037 W=2, frame 1 = 1,1,0,0 then frame 2 = 0,1,0,1, with din_valid low for 3 cycles between beats -> a single out_valid after frame 2, with y0=10, y1=11, y2=00, y3=01.
REQ-038 Beats before any sync -> no out_valid, locked=0, slot=00.
REQ-039 In RUN, sync on the slot-10 beat -> sync_err pulses once, slot=01, and y0..y3 are unchanged.
REQ-040 rst asserted after 2 beats of a frame -> all outputs 0, and 4 further beats without sync produce no out_valid.
